// File: rtl/timer_input_capture.sv
// ---------------------------------------------------------------------------
// timer_input_capture
//
// Purpose:
//    Input-capture unit for the PLC timer subsystem. Measures the period
//    between qualifying edges of an external asynchronous input, counted in
//    prescaler ticks (PRESCALER_OV pulses). Each measured period is handed to
//    the CPU through a valid/ack register handshake. A capture that arrives
//    while an unread one is still pending is dropped and flagged.
//
// Parameters:
//    CNT_WIDTH    width of the period counter and CAP_VALUE
//    SYNC_STAGES  flip-flop stages in the CAP_IN synchroniser (>= 2)
//    FILTER_LEN   stable cycles required by the glitch filter
//
// Ports:
//    CLK           in   system clock, rising edge
//    CPU_Reset_n   in   asynchronous active-low reset
//    CAP_EN        in   unit enable; low returns the unit to IDLE
//    CAP_EDGE_SEL  in   2  00 rising, 01 falling, 10 both, 11 rising
//    CAP_IN        in   asynchronous external signal to measure
//    PRESCALER_OV  in   single-cycle tick from the timer prescaler
//    CAP_ACK       in   single-cycle CPU read acknowledge
//    CAP_VALUE     out  CNT_WIDTH  last captured period in ticks
//    CAP_VALID     out  CAP_VALUE holds an unread capture
//    CAP_OVF       out  the capture in CAP_VALUE saturated
//    CAP_MISSED    out  one-cycle pulse when a capture is dropped
//    CAP_BUSY      out  high while armed or measuring
//
// Build option:
//    CAP_FILTER_EN  when defined, a FILTER_LEN-deep stability filter is
//                   inserted after the synchroniser; pulses shorter than
//                   FILTER_LEN cycles never reach the edge detector.
// ---------------------------------------------------------------------------
module timer_input_capture #(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic                 CLK,
   input  logic                 CPU_Reset_n,
   input  logic                 CAP_EN,
   input  logic [1:0]           CAP_EDGE_SEL,
   input  logic                 CAP_IN,
   input  logic                 PRESCALER_OV,
   input  logic                 CAP_ACK,
   output logic [CNT_WIDTH-1:0] CAP_VALUE,
   output logic                 CAP_VALID,
   output logic                 CAP_OVF,
   output logic                 CAP_MISSED,
   output logic                 CAP_BUSY
);

   // Reject configurations the synchroniser and filter cannot support.
   generate
      if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
         $error("timer_input_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // ------------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_level;
   logic                   cap_level;
   logic                   level_d_q;
   logic                   rise_det;
   logic                   fall_det;
   logic                   edge_qual;

   // CAP_IN is fully asynchronous, so it is shifted through a plain flop
   // chain before anything else looks at it.
   always_ff @(posedge CLK or negedge CPU_Reset_n) begin
      if (!CPU_Reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], CAP_IN};
      end
   end

   assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef CAP_FILTER_EN
   localparam int FILT_CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FILT_CW-1:0] FILT_LAST = FILT_CW'(FILTER_LEN - 1);

   logic [FILT_CW-1:0] filt_cnt_q;
   logic               filt_level_q;

   // The filtered level follows the synchroniser only after it has held a
   // differing value for FILTER_LEN consecutive cycles. Any return to the
   // current filtered level restarts the count, so short glitches vanish.
   always_ff @(posedge CLK or negedge CPU_Reset_n) begin
      if (!CPU_Reset_n) begin
         filt_cnt_q   <= '0;
         filt_level_q <= 1'b0;
      end else if (sync_level == filt_level_q) begin
         filt_cnt_q   <= '0;
      end else if (filt_cnt_q == FILT_LAST) begin
         filt_cnt_q   <= '0;
         filt_level_q <= sync_level;
      end else begin
         filt_cnt_q   <= filt_cnt_q + FILT_CW'(1);
      end
   end

   assign cap_level = filt_level_q;
`else
   assign cap_level = sync_level;
`endif

   // One-cycle history of the conditioned level for edge detection. It keeps
   // tracking even while idle so that enabling the unit never produces a
   // phantom edge from stale history.
   always_ff @(posedge CLK or negedge CPU_Reset_n) begin
      if (!CPU_Reset_n) begin
         level_d_q <= 1'b0;
      end else begin
         level_d_q <= cap_level;
      end
   end

   assign rise_det = cap_level & ~level_d_q;
   assign fall_det = ~cap_level & level_d_q;

   // Edge selection; the reserved encoding 11 behaves like rising.
   always_comb begin
      edge_qual = rise_det;
      case (CAP_EDGE_SEL)
         2'b01:   edge_qual = fall_det;
         2'b10:   edge_qual = rise_det | fall_det;
         default: edge_qual = rise_det;
      endcase
   end

   // ------------------------------------------------------------------------
   // Measurement FSM and capture register
   // ------------------------------------------------------------------------
   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic                   ovf_q;
   logic                   ovf_d;
   logic                   capture;
   logic [CNT_WIDTH-1:0]   value_d;
   logic                   valid_d;
   logic                   cap_ovf_d;
   logic                   missed_d;
   logic                   busy_d;

   // All sequential state of the unit. CAP_BUSY is registered from the next
   // state so it changes on the same edge as the state register itself.
   always_ff @(posedge CLK or negedge CPU_Reset_n) begin
      if (!CPU_Reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         CAP_VALUE  <= '0;
         CAP_VALID  <= 1'b0;
         CAP_OVF    <= 1'b0;
         CAP_MISSED <= 1'b0;
         CAP_BUSY   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         CAP_VALUE  <= value_d;
         CAP_VALID  <= valid_d;
         CAP_OVF    <= cap_ovf_d;
         CAP_MISSED <= missed_d;
         CAP_BUSY   <= busy_d;
      end
   end

   // Next-state and counter logic. A qualifying edge restarts the period
   // count; a tick arriving in that same cycle belongs to the new period,
   // so the restart value is 1 rather than 0 and the captured value does
   // not include it. Once the counter is at all-ones further ticks are
   // absorbed and remembered in the overflow flag instead.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      capture = 1'b0;

      if (!CAP_EN) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end

            ST_ARM: begin
               if (edge_qual) begin
                  state_d = ST_MEASURE;
                  cnt_d   = PRESCALER_OV ? CNT_ONE : '0;
                  ovf_d   = 1'b0;
               end
            end

            ST_MEASURE: begin
               if (edge_qual) begin
                  capture = 1'b1;
                  cnt_d   = PRESCALER_OV ? CNT_ONE : '0;
                  ovf_d   = 1'b0;
               end else if (PRESCALER_OV) begin
                  if (cnt_q == CNT_MAX) begin
                     ovf_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Capture handshake. A new capture is accepted when the register is free
   // or is being acknowledged in the same cycle; otherwise it is dropped and
   // CAP_MISSED pulses. An acknowledge without a new capture frees the
   // register but leaves the last value readable.
   always_comb begin
      value_d   = CAP_VALUE;
      valid_d   = CAP_VALID;
      cap_ovf_d = CAP_OVF;
      missed_d  = 1'b0;

      if (capture) begin
         if (!CAP_VALID || CAP_ACK) begin
            value_d   = cnt_q;
            cap_ovf_d = ovf_q;
            valid_d   = 1'b1;
         end else begin
            missed_d  = 1'b1;
         end
      end else if (CAP_ACK && CAP_VALID) begin
         valid_d   = 1'b0;
         cap_ovf_d = 1'b0;
      end
   end

endmodule
